// File: rtl/cpu_mem_host_pkg.sv
// cpu_mem_host_pkg: shared opcodes, FSM encoding and memory depth for cpu_mem_host.
package cpu_mem_host_pkg;
  localparam logic [4:0] NOP_OP = 5'b00000;
  localparam logic [4:0] HALT_OP = 5'b00001;
  localparam int MEM_DEPTH = 256;
  typedef enum logic [2:0] {IDLE, RST, ARM, START, RUN, HALTED} state_t;
endpackage

// File: rtl/cpu_mem_ram.sv
// cpu_mem_ram: 256x16 memory with one synchronous write port and an asynchronous read port.
module cpu_mem_ram
  import cpu_mem_host_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [7:0]  raddr,
  output logic [15:0] rdata
);
  logic [15:0] mem [MEM_DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_mem_host.sv
// cpu_mem_host: host loader and run sequencer around instruction/data memories for a CPU.
// Define CPU_MEM_WATCHDOG_EN to halt a run that reaches WATCHDOG_LIMIT cycles.
module cpu_mem_host
  import cpu_mem_host_pkg::*;
#(
  parameter logic [15:0] WATCHDOG_LIMIT = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic        ld_sel,
  input  logic [7:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  input  logic        run_req,
  input  logic [7:0]  i_addr,
  output logic [15:0] i_datain,
  input  logic [7:0]  d_addr,
  input  logic [15:0] d_dataout,
  input  logic        d_we,
  output logic [15:0] d_datain,
  output logic        cpu_reset,
  output logic        cpu_enable,
  output logic        cpu_start,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycle_count
);
  state_t state, state_n;
  logic rst_cnt, idle_like, in_run, start_run, ld_ok, halt_hit, wd_hit;
  logic dm_we;
  logic [7:0] dm_waddr;
  logic [15:0] dm_wdata, im_rdata;
  assign idle_like = (state == IDLE) || (state == HALTED);
  assign in_run = state == RUN;
  assign start_run = idle_like && run_req;
  assign ld_ready = idle_like && !run_req;
  assign ld_ok = ld_ready && ld_valid;
  assign cpu_reset = (state == ARM) || (state == START) || in_run;
  assign cpu_enable = cpu_reset;
  assign cpu_start = state == START;
  assign i_datain = in_run ? im_rdata : {NOP_OP, 11'b0};
  assign halt_hit = in_run && (i_datain[15:11] == HALT_OP);
  // The CPU owns the dmem write port only while running; otherwise the loader does.
  assign dm_we = in_run ? d_we : ld_ok && ld_sel;
  assign dm_waddr = in_run ? d_addr : ld_addr;
  assign dm_wdata = in_run ? d_dataout : ld_data;
  cpu_mem_ram u_imem (
    .clk(clock), .we(ld_ok && !ld_sel), .waddr(ld_addr), .wdata(ld_data),
    .raddr(i_addr), .rdata(im_rdata)
  );
  cpu_mem_ram u_dmem (
    .clk(clock), .we(dm_we), .waddr(dm_waddr), .wdata(dm_wdata),
    .raddr(d_addr), .rdata(d_datain)
  );
`ifdef CPU_MEM_WATCHDOG_EN
  assign wd_hit = in_run && !halt_hit && (cycle_count == WATCHDOG_LIMIT);
  always_ff @(posedge clock or posedge reset)
    if (reset) timeout <= 1'b0;
    else if (start_run) timeout <= 1'b0;
    else if (wd_hit) timeout <= 1'b1;
`else
  logic unused_wd;
  assign unused_wd = ^WATCHDOG_LIMIT;
  assign wd_hit = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE, HALTED: state_n = run_req ? RST : state;
      RST:          state_n = rst_cnt ? ARM : RST;
      ARM:          state_n = START;
      START:        state_n = RUN;
      RUN:          state_n = (halt_hit || wd_hit) ? HALTED : RUN;
      default:      state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      rst_cnt <= 1'b0;
      cycle_count <= 16'h0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      rst_cnt <= (state == RST) ? ~rst_cnt : 1'b0;
      if (start_run) begin
        cycle_count <= 16'h0;
        done <= 1'b0;
      end else if (in_run) begin
        if (!wd_hit && cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'h1;
        if (halt_hit || wd_hit) done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_cpu_mem_host.sv
// tb_cpu_mem_host: randomized directed bench for cpu_mem_host against a memory/run model.
module tb_cpu_mem_host;
  logic clock = 1'b0, reset = 1'b1;
  logic ld_valid = 1'b0, ld_sel = 1'b0, run_req = 1'b0, d_we = 1'b0;
  logic [7:0] ld_addr = '0, i_addr = '0, d_addr = '0;
  logic [15:0] ld_data = '0, d_dataout = '0;
  logic ld_ready, cpu_reset, cpu_enable, cpu_start, done, timeout;
  logic [15:0] i_datain, d_datain, cycle_count;
  int errors = 0, checks = 0;
  logic [15:0] imem_m [256];
  logic [15:0] dmem_m [256];
  logic [7:0] addrs [8];
  int n;

  cpu_mem_host #(.WATCHDOG_LIMIT(16'd20)) dut (
    .clock(clock), .reset(reset), .ld_valid(ld_valid), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready), .run_req(run_req),
    .i_addr(i_addr), .i_datain(i_datain), .d_addr(d_addr), .d_dataout(d_dataout),
    .d_we(d_we), .d_datain(d_datain), .cpu_reset(cpu_reset), .cpu_enable(cpu_enable),
    .cpu_start(cpu_start), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic sel, input logic [7:0] a, input logic [15:0] v);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = a; ld_data = v;
    #1 chk("ld_ready_idle", {15'b0, ld_ready}, 16'd1);
    tick();
    ld_valid = 1'b0;
    if (sel) dmem_m[a] = v; else imem_m[a] = v;
  endtask

  task automatic run_to_run();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    @(negedge clock);
    #1;
    chk("rst_cpu_reset", {15'b0, cpu_reset}, 16'd0);
    chk("rst_cpu_enable", {15'b0, cpu_enable}, 16'd0);
    chk("rst_cpu_start", {15'b0, cpu_start}, 16'd0);
    chk("rst_done", {15'b0, done}, 16'd0);
    chk("rst_timeout", {15'b0, timeout}, 16'd0);
    chk("rst_cycle_count", cycle_count, 16'd0);
    chk("rst_ld_ready", {15'b0, ld_ready}, 16'd1);
    chk("rst_i_datain_nop", i_datain, 16'h0000);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 8'($urandom_range(32, 255));
      load(1'b1, addrs[i], 16'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      d_addr = addrs[i];
      #1 chk("dmem_load_read", d_datain, dmem_m[addrs[i]]);
    end
    n = $urandom_range(3, 8);
    for (int k = 0; k < n; k++) begin
      logic [4:0] op;
      op = 5'($urandom);
      if (op == 5'b00001) op = 5'b00010;
      load(1'b0, 8'(k), {op, 11'($urandom)});
    end
    load(1'b0, 8'(n), {5'b00001, 11'b0});
    // run_req and a load in the same idle cycle: run wins, no write
    run_req = 1'b1; ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = addrs[0];
    ld_data = ~dmem_m[addrs[0]];
    #1 chk("ld_ready_runreq", {15'b0, ld_ready}, 16'd0);
    tick();
    run_req = 1'b0; ld_valid = 1'b0;
    #1 chk("rst1_cpu_reset", {15'b0, cpu_reset}, 16'd0);
    chk("rst1_cpu_enable", {15'b0, cpu_enable}, 16'd0);
    chk("rst1_cpu_start", {15'b0, cpu_start}, 16'd0);
    chk("rst1_ld_ready", {15'b0, ld_ready}, 16'd0);
    tick();
    #1 chk("rst2_cpu_reset", {15'b0, cpu_reset}, 16'd0);
    chk("rst2_cpu_start", {15'b0, cpu_start}, 16'd0);
    tick();
    #1 chk("arm_cpu_reset", {15'b0, cpu_reset}, 16'd1);
    chk("arm_cpu_enable", {15'b0, cpu_enable}, 16'd1);
    chk("arm_cpu_start", {15'b0, cpu_start}, 16'd0);
    tick();
    i_addr = 8'd0; d_addr = addrs[0];
    #1 chk("start_cpu_start", {15'b0, cpu_start}, 16'd1);
    chk("start_i_datain_nop", i_datain, 16'h0000);
    chk("runreq_load_blocked", d_datain, dmem_m[addrs[0]]);
    tick();
    for (int k = 0; k <= n; k++) begin
      i_addr = 8'(k);
      #1 chk("run_i_datain", i_datain, imem_m[k]);
      chk("run_cycle_count", cycle_count, 16'(k));
      chk("run_cpu_start", {15'b0, cpu_start}, 16'd0);
      chk("run_cpu_enable", {15'b0, cpu_enable}, 16'd1);
      if (k == 0) begin
        d_addr = 8'h10; d_dataout = 16'h0082; d_we = 1'b1;
        dmem_m[8'h10] = 16'h0082;
      end else if (k == 1) begin
        d_we = 1'b0;
        chk("cpu_write_read", d_datain, 16'h0082);
        ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 8'h10; ld_data = 16'hBEEF; run_req = 1'b1;
        #1 chk("run_ld_ready", {15'b0, ld_ready}, 16'd0);
      end else if (k == 2) begin
        chk("run_load_ignored", d_datain, 16'h0082);
        ld_valid = 1'b0; run_req = 1'b0;
      end
      tick();
    end
    #1 chk("halt_done", {15'b0, done}, 16'd1);
    chk("halt_cycle_count", cycle_count, 16'(n + 1));
    chk("halt_timeout", {15'b0, timeout}, 16'd0);
    chk("halt_i_datain_nop", i_datain, 16'h0000);
    chk("halt_ld_ready", {15'b0, ld_ready}, 16'd1);
    tick(); tick();
    #1 chk("done_sticky", {15'b0, done}, 16'd1);
    chk("count_held", cycle_count, 16'(n + 1));
    addrs[1] = 8'($urandom_range(32, 255));
    load(1'b1, addrs[1], 16'($urandom));
    d_addr = addrs[1];
    #1 chk("halted_load", d_datain, dmem_m[addrs[1]]);
    run_to_run();
    i_addr = 8'd0;
    #1 chk("rerun_done_clear", {15'b0, done}, 16'd0);
    chk("rerun_enable", {15'b0, cpu_enable}, 16'd1);
    tick();
    #1 reset = 1'b1;
    #1 chk("midrun_cpu_reset", {15'b0, cpu_reset}, 16'd0);
    chk("midrun_cpu_enable", {15'b0, cpu_enable}, 16'd0);
    chk("midrun_cycle_count", cycle_count, 16'd0);
    chk("midrun_ld_ready", {15'b0, ld_ready}, 16'd1);
    chk("midrun_i_datain", i_datain, 16'h0000);
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      d_addr = addrs[i];
      #1 chk("dmem_retained", d_datain, dmem_m[addrs[i]]);
    end
    d_addr = 8'h10;
    #1 chk("dmem_retained_10", d_datain, 16'h0082);
`ifdef CPU_MEM_WATCHDOG_EN
    load(1'b0, 8'd0, 16'h0000);
    run_to_run();
    i_addr = 8'd0;
    for (int c = 0; c < 60 && !done; c++) tick();
    #1 chk("wd_done", {15'b0, done}, 16'd1);
    chk("wd_timeout", {15'b0, timeout}, 16'd1);
    chk("wd_cycle_count", cycle_count, 16'd20);
`else
    chk("no_wd_timeout", {15'b0, timeout}, 16'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
